mix_columns_seq: RTL and testbench

MIX_COLUMNS_SEQ -- requirements
Module: mix_columns_seq

---
 rtl/aes_pkg.sv | 36 +++
 rtl/mix_col_unit.sv | 37 +++
 rtl/mix_columns_seq.sv | 125 ++++++++++++
 tb/tb_mix_columns_seq.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions for the MixColumns datapath: state geometry,
// FSM encoding, GF(2^8) helpers and the circulant coefficient rows.
package aes_pkg;

  localparam int STATE_W = 128;
  localparam int NCOLS   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Circulant first rows, element [0] applies to the column's own row.
  localparam logic [3:0][7:0] FWD_COEF = {8'h01, 8'h01, 8'h03, 8'h02};
  localparam logic [3:0][7:0] INV_COEF = {8'h09, 8'h0d, 8'h0b, 8'h0e};

  // Multiply by x modulo x^8 + x^4 + x^3 + x + 1 (0x11b).
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Shift-and-add GF(2^8) product; folds to a few XORs for constant b.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

endpackage

// File: rtl/mix_col_unit.sv
// One-column MixColumns: 32-bit column (row 0 in the MSB byte) times the
// forward or inverse circulant. Inverse coefficients exist only when
// MIXCOL_INV_EN is defined; otherwise inv_i is ignored.
module mix_col_unit
  import aes_pkg::*;
(
  input  logic [31:0] col_i,
  input  logic        inv_i,
  output logic [31:0] col_o
);

  logic [3:0][7:0] coef;

`ifdef MIXCOL_INV_EN
  assign coef = inv_i ? INV_COEF : FWD_COEF;
`else
  logic unused_inv;
  assign unused_inv = inv_i;
  assign coef       = FWD_COEF;
`endif

  // Row r of the result: XOR over k of coef[(k - r) mod 4] * a[k].
  always_comb begin
    // NOTE: every output gets a default before any conditional/loop write,
    // so the block stays purely combinational (no latch inferred).
    col_o = '0;
    for (int r = 0; r < 4; r++) begin
      logic [7:0] acc;
      acc = '0;
      for (int k = 0; k < 4; k++) begin
        acc = acc ^ gf_mul(col_i[8*(3-k) +: 8], coef[2'(k - r)]);
      end
      col_o[8*(3-r) +: 8] = acc;
    end
  end

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns: accepts a 128-bit state, transforms
// COLS_PER_CYCLE columns per BUSY cycle in place, then presents the result
// in DONE until the consumer takes it. Macro MIXCOL_INV_EN adds the
// inverse transform selected by in_inv; without it every block is forward.
module mix_columns_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_inv,
  input  logic [STATE_W-1:0] in_state,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_state
);

  localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_CNT = 2'(NCOLS - COLS_PER_CYCLE);

  state_e             state_q, state_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [STATE_W-1:0] data_q, data_d;
  logic               accept;
  logic               mode;

  logic [COLS_PER_CYCLE-1:0][1:0]  col_idx;
  logic [COLS_PER_CYCLE-1:0][31:0] col_in;
  logic [COLS_PER_CYCLE-1:0][31:0] col_out;

  assign in_ready  = !rst && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign out_state = data_q;

`ifdef MIXCOL_INV_EN
  logic inv_q;

  // Latch the mode at accept so later in_inv changes cannot reach the block in flight.
  always_ff @(posedge clk) begin
    if (rst)         inv_q <= 1'b0;
    else if (accept) inv_q <= in_inv;
  end

  assign mode = inv_q;
`else
  logic unused_in_inv;
  assign unused_in_inv = in_inv;
  assign mode          = 1'b0;
`endif

  // Pick the columns addressed by the counter; column c sits at bits [127-32c -: 32].
  always_comb begin
    col_idx = '0;
    col_in  = '0;
    for (int j = 0; j < COLS_PER_CYCLE; j++) begin
      col_idx[j] = cnt_q + 2'(j);
      col_in[j]  = data_q[{~col_idx[j], 5'b00000} +: 32];
    end
  end

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_unit
    mix_col_unit u_col (
      .col_i (col_in[g]),
      .inv_i (mode),
      .col_o (col_out[g])
    );
  end

  // Next-state logic: accept, in-place column update, output handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          data_d  = in_state;
          cnt_d   = 2'd0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
          data_d[{~col_idx[j], 5'b00000} +: 32] = col_out[j];
        end
        cnt_d = cnt_q + CNT_STEP;
        if (cnt_q == LAST_CNT) state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          if (accept) begin
            data_d  = in_state;
            cnt_d   = 2'd0;
            state_d = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset taking priority over any handshake.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      // NOTE: the wide data register is reset as well because out_state must
      // read zero after reset; it is a register, not a RAM, so this is cheap.
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed self-checking bench for mix_columns_seq: a COLS_PER_CYCLE=1
// instance carries the handshake, hold, back-to-back and reset-abort
// scenarios; instances with 2 and 4 columns per cycle check latency and
// results on the same vectors. Mode-dependent expectations follow
// MIXCOL_INV_EN.
module tb_mix_columns_seq;

  localparam logic [127:0] VA    = {4{32'hdb135345}};
  localparam logic [127:0] EXP_A = {4{32'h8e4da1bc}};
  localparam logic [127:0] VB    = {32'hf20a225c, 32'h01010101, 32'hc6c6c6c6, 32'h2d26314c};
  localparam logic [127:0] EXP_B = {32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6, 32'h4d7ebdf8};
  localparam logic [127:0] JUNK  = 128'h0123456789abcdef_fedcba9876543210;
`ifdef MIXCOL_INV_EN
  localparam logic [127:0] VC    = {4{32'h8e4da1bc}};
  localparam logic [127:0] EXP_C = {4{32'hdb135345}};
`else
  localparam logic [127:0] VC    = {4{32'hdb135345}};
  localparam logic [127:0] EXP_C = {4{32'h8e4da1bc}};
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_inv;
  logic [127:0] in_state;

  logic         in_valid1, in_ready1, out_valid1, out_ready1;
  logic [127:0] out_state1;
  logic         in_valid2, in_ready2, out_valid2, out_ready2;
  logic [127:0] out_state2;
  logic         in_valid4, in_ready4, out_valid4, out_ready4;
  logic [127:0] out_state4;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  mix_columns_seq #(.COLS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_inv(in_inv), .in_state(in_state), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_state(out_state1)
  );

  mix_columns_seq #(.COLS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_inv(in_inv), .in_state(in_state), .out_valid(out_valid2),
    .out_ready(out_ready2), .out_state(out_state2)
  );

  mix_columns_seq #(.COLS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_inv(in_inv), .in_state(in_state), .out_valid(out_valid4),
    .out_ready(out_ready4), .out_state(out_state4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bounded wait for dut1 out_valid; lat stays 0 when the budget expires.
  task automatic wait_out1(output int lat);
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (out_valid1) begin
        lat = i;
        break;
      end
    end
  endtask

  // Offer one block to the 2- and 4-column instances and check both.
  task automatic run_wide(input string tag, input logic [127:0] vin,
                          input logic inv, input logic [127:0] exp);
    int           lat2, lat4;
    logic [127:0] res2, res4;
    lat2 = 0; lat4 = 0; res2 = '0; res4 = '0;
    in_state  = vin;
    in_inv    = inv;
    in_valid2 = 1'b1;
    in_valid4 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    in_valid4 = 1'b0;
    in_state  = JUNK;
    in_inv    = ~inv;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (out_valid2 && lat2 == 0) begin lat2 = i; res2 = out_state2; end
      if (out_valid4 && lat4 == 0) begin lat4 = i; res4 = out_state4; end
    end
    check({tag, "_lat_cpc2"}, 128'(lat2), 128'd2);
    check({tag, "_res_cpc2"}, res2, exp);
    check({tag, "_lat_cpc4"}, 128'(lat4), 128'd1);
    check({tag, "_res_cpc4"}, res4, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int   lat;
    logic seen;

    rst = 1'b1; in_inv = 1'b0; in_state = '0;
    in_valid1 = 1'b0; out_ready1 = 1'b0;
    in_valid2 = 1'b0; out_ready2 = 1'b1;
    in_valid4 = 1'b0; out_ready4 = 1'b1;

    // Reset state
    tick(); tick();
    check("rst_out_valid", 128'(out_valid1), 128'd0);
    check("rst_out_state", out_state1, 128'd0);
    check("rst_in_ready_low", 128'(in_ready1), 128'd0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", 128'(in_ready1), 128'd1);

    // Forward block A; in_valid stays high with junk during BUSY and DONE-hold
    in_state = VA; in_inv = 1'b0; in_valid1 = 1'b1;
    tick();
    in_state = JUNK; in_inv = 1'b1;
    check("busy_in_ready", 128'(in_ready1), 128'd0);
    check("busy_out_valid", 128'(out_valid1), 128'd0);
    wait_out1(lat);
    check("a_latency", 128'(lat), 128'd4);
    check("a_result", out_state1, EXP_A);

    // Hold DONE with out_ready low while block B is offered
    in_state = VB; in_inv = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_out_valid", 128'(out_valid1), 128'd1);
      check("hold_out_state", out_state1, EXP_A);
      check("hold_in_ready", 128'(in_ready1), 128'd0);
    end

    // Release: output completes and block B is accepted in the same cycle
    out_ready1 = 1'b1;
    #1;
    check("b2b_in_ready", 128'(in_ready1), 128'd1);
    tick();
    out_ready1 = 1'b0; in_valid1 = 1'b0;
    check("b2b_busy_out_valid", 128'(out_valid1), 128'd0);
    wait_out1(lat);
    check("b_latency", 128'(lat), 128'd4);
    check("b_result", out_state1, EXP_B);

    // Drain to IDLE
    out_ready1 = 1'b1;
    tick();
    check("drain_out_valid", 128'(out_valid1), 128'd0);
    check("drain_in_ready", 128'(in_ready1), 128'd1);

    // Mode-select block: inverse when built in, forced forward otherwise
    in_state = VC; in_inv = 1'b1; in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0; in_state = JUNK; in_inv = 1'b0;
    wait_out1(lat);
    check("c_latency", 128'(lat), 128'd4);
    check("c_result", out_state1, EXP_C);
    tick();

    // Reset during the second BUSY cycle aborts the block
    in_state = VA; in_inv = 1'b0; in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("abort_rst_in_ready", 128'(in_ready1), 128'd0);
    tick();
    rst = 1'b0;
    #1;
    check("abort_out_state", out_state1, 128'd0);
    check("abort_out_valid", 128'(out_valid1), 128'd0);
    check("abort_in_ready", 128'(in_ready1), 128'd1);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid1) seen = 1'b1;
    end
    check("abort_no_output", 128'(seen), 128'd0);

    // Wider datapaths on the same vectors
    run_wide("wide_a", VA, 1'b0, EXP_A);
    run_wide("wide_b", VB, 1'b0, EXP_B);
    run_wide("wide_c", VC, 1'b1, EXP_C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
